// File: rtl/ntt_stage_permute_seq_if.sv
// Lane-permutation stage bus: input beat stream, permuted output stream, sticky error flags.
interface ntt_stage_permute_seq_if #(
  parameter int unsigned DATA_WIDTH = 28,
  parameter int unsigned LANES      = 64
);
  localparam int unsigned LOG2_LANES = $clog2(LANES);
  localparam int unsigned BUS_W      = LANES * DATA_WIDTH;

  logic                  in_valid;
  logic                  in_start;
  logic [LOG2_LANES-1:0] cfg_bit;
  logic [BUS_W-1:0]      in_data;
  logic                  out_valid;
  logic                  out_start;
  logic                  out_last;
  logic [BUS_W-1:0]      out_data;
  logic                  err_cfg;
  logic                  err_rstrt;

  modport master (
    output in_valid, in_start, cfg_bit, in_data,
    input  out_valid, out_start, out_last, out_data, err_cfg, err_rstrt
  );

  modport slave (
    input  in_valid, in_start, cfg_bit, in_data,
    output out_valid, out_start, out_last, out_data, err_cfg, err_rstrt
  );
endinterface

// File: rtl/ntt_stage_permute_seq.sv
// Runtime-configurable inter-stage lane permutation for the streaming NTT/INTT datapath.
// Each beat swaps lane-index bit 0 with bit P (P latched on the frame start beat) and
// tracks frame start/last over BEATS beats.
// Optional macro NTT_PERM_PIPE2_EN: second register stage on out_* (latency 2);
// error flags keep single-cycle timing.
module ntt_stage_permute_seq #(
  parameter int unsigned DATA_WIDTH = 28,
  parameter int unsigned LANES      = 64,
  parameter int unsigned BEATS      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  ntt_stage_permute_seq_if.slave  bus
);
  localparam int unsigned LOG2_LANES = $clog2(LANES);
  localparam int unsigned BUS_W      = LANES * DATA_WIDTH;
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [LOG2_LANES-1:0] p_q, p_nxt;

  logic                  acc_c, first_c, last_c, rstrt_c, cfg_bad_c, p_ok_c;
  logic [BUS_W-1:0]      perm_c;
  int                    src;

  logic                  v_q, s_q, l_q;
  logic [BUS_W-1:0]      d_q;
  logic                  err_cfg_q, err_rstrt_q;

  // Frame tracking: beat acceptance, framing markers and next FSM/counter/P values.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    p_nxt     = p_q;
    acc_c     = 1'b0;
    first_c   = 1'b0;
    last_c    = 1'b0;
    rstrt_c   = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_start) begin
        acc_c   = 1'b1;
        first_c = 1'b1;
        p_nxt   = bus.cfg_bit;
        rstrt_c = (state == S_RUN);
        if (BEATS == 1) begin
          last_c    = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = S_RUN;
          cnt_nxt   = CNT_W'(1);
        end
      end else if (state == S_RUN) begin
        acc_c = 1'b1;
        if (cnt == CNT_W'(BEATS - 1)) begin
          last_c    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    end
  end

  assign cfg_bad_c = first_c && (32'(bus.cfg_bit) >= LOG2_LANES);
  // p_nxt is the freshly sampled cfg_bit on a start beat, else the frame's latched P.
  assign p_ok_c    = 32'(p_nxt) < LOG2_LANES;

  // Lane mux: output lane i reads the input lane whose index has bits 0 and P exchanged.
  always_comb begin
    perm_c = '0;
    src    = 0;
    for (int i = 0; i < int'(LANES); i++) begin
      src = i;
      if (p_ok_c && (((i >> p_nxt) & 1) != (i & 1)))
        src = i ^ (1 | (1 << p_nxt));
      perm_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_data[src*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM state, beat counter and latched partner bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      p_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      p_q   <= p_nxt;
    end
  end

  // First output stage and sticky error flags; data holds across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= 1'b0;
      s_q         <= 1'b0;
      l_q         <= 1'b0;
      d_q         <= '0;
      err_cfg_q   <= 1'b0;
      err_rstrt_q <= 1'b0;
    end else begin
      v_q <= acc_c;
      s_q <= first_c;
      l_q <= last_c;
      if (acc_c)     d_q         <= perm_c;
      if (cfg_bad_c) err_cfg_q   <= 1'b1;
      if (rstrt_c)   err_rstrt_q <= 1'b1;
    end
  end

  assign bus.err_cfg   = err_cfg_q;
  assign bus.err_rstrt = err_rstrt_q;

`ifdef NTT_PERM_PIPE2_EN
  logic             v2_q, s2_q, l2_q;
  logic [BUS_W-1:0] d2_q;

  // Second output stage: delays all out_* together by one more cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
      s2_q <= 1'b0;
      l2_q <= 1'b0;
      d2_q <= '0;
    end else begin
      v2_q <= v_q;
      s2_q <= s_q;
      l2_q <= l_q;
      d2_q <= d_q;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.out_start = s2_q;
  assign bus.out_last  = l2_q;
  assign bus.out_data  = d2_q;
`else
  assign bus.out_valid = v_q;
  assign bus.out_start = s_q;
  assign bus.out_last  = l_q;
  assign bus.out_data  = d_q;
`endif

endmodule

// File: tb/tb_ntt_stage_permute_seq.sv
// Bench for ntt_stage_permute_seq: directed scenarios plus random traffic against a
// frame-level reference model (beat index within frame, lane bit swap by bit arrays).
module tb_ntt_stage_permute_seq;
  localparam int DW    = 28;
  localparam int LANES = 64;
  localparam int BEATS = 8;
  localparam int LOG2  = 6;
  localparam int BUS_W = LANES * DW;

  logic clk;
  logic rst;

  ntt_stage_permute_seq_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus ();

  ntt_stage_permute_seq #(.DATA_WIDTH(DW), .LANES(LANES), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit               m_active;
  int               m_idx;
  int               m_p;
  logic             m_ecfg, m_erst;
  logic             s1_v, s1_s, s1_l;
  logic [BUS_W-1:0] s1_d;
  logic             e_v, e_s, e_l;
  logic [BUS_W-1:0] e_d;

  function automatic logic [BUS_W-1:0] ref_perm(input logic [BUS_W-1:0] d, input int p);
    logic [BUS_W-1:0] r;
    int bits [LOG2];
    int j, t;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < LOG2; k++) bits[k] = (i >> k) & 1;
      if (p < LOG2) begin
        t = bits[0]; bits[0] = bits[p]; bits[p] = t;
      end
      j = 0;
      for (int k = 0; k < LOG2; k++) j += bits[k] << k;
      r[i*DW +: DW] = d[j*DW +: DW];
    end
    return r;
  endfunction

  function automatic logic [BUS_W-1:0] ramp(input int beat);
    logic [BUS_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(i + 64 * beat);
    return r;
  endfunction

  function automatic logic [BUS_W-1:0] rnd_bus();
    logic [BUS_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_lane(input string tag, input int lane, input logic [DW-1:0] exp);
    logic [DW-1:0] obs;
    obs = bus.out_data[lane*DW +: DW];
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s lane=%0d observed=%0d expected=%0d", tag, lane, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [BUS_W-1:0] exp);
    int first;
    first = -1;
    for (int i = LANES - 1; i >= 0; i--)
      if (bus.out_data[i*DW +: DW] !== exp[i*DW +: DW]) first = i;
    total++;
    assert (bus.out_data === exp) else begin
      bad++;
      $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, first,
             bus.out_data[first*DW +: DW], exp[first*DW +: DW]);
    end
  endtask

  // Advance the model by one cycle of inputs.
  task automatic model(input logic v, input logic s, input logic [LOG2-1:0] cfg,
                       input logic [BUS_W-1:0] d);
    logic n_v, n_s, n_l;
    logic [BUS_W-1:0] n_d;
    bit acc;
    n_v = 1'b0; n_s = 1'b0; n_l = 1'b0; n_d = s1_d; acc = 0;
    if (rst) begin
      m_active = 0; m_idx = 0; m_p = 0; m_ecfg = 1'b0; m_erst = 1'b0;
      n_d = '0;
      s1_v = 1'b0; s1_s = 1'b0; s1_l = 1'b0; s1_d = '0;
    end else if (v) begin
      if (s) begin
        if (m_active) m_erst = 1'b1;
        m_p = int'(cfg);
        if (int'(cfg) >= LOG2) m_ecfg = 1'b1;
        m_idx = 0; m_active = 1; acc = 1; n_s = 1'b1;
      end else if (m_active) begin
        acc = 1;
      end
      if (acc) begin
        n_v = 1'b1;
        n_l = (m_idx == BEATS - 1);
        n_d = ref_perm(d, m_p);
        m_idx++;
        if (n_l) begin m_active = 0; m_idx = 0; end
      end
    end
`ifdef NTT_PERM_PIPE2_EN
    if (rst) begin
      e_v = 1'b0; e_s = 1'b0; e_l = 1'b0; e_d = '0;
    end else begin
      e_v = s1_v; e_s = s1_s; e_l = s1_l; e_d = s1_d;
    end
`endif
    s1_v = n_v; s1_s = n_s; s1_l = n_l; s1_d = n_d;
`ifndef NTT_PERM_PIPE2_EN
    e_v = s1_v; e_s = s1_s; e_l = s1_l; e_d = s1_d;
`endif
  endtask

  task automatic step(input logic v, input logic s, input logic [LOG2-1:0] cfg,
                      input logic [BUS_W-1:0] d);
    bus.in_valid = v;
    bus.in_start = s;
    bus.cfg_bit  = cfg;
    bus.in_data  = d;
    model(v, s, cfg, d);
    @(posedge clk);
    #1;
    check_bit("out_valid", bus.out_valid, e_v);
    check_bit("out_start", bus.out_start, e_s);
    check_bit("out_last", bus.out_last, e_l);
    check_bus("out_data", e_d);
    check_bit("err_cfg", bus.err_cfg, m_ecfg);
    check_bit("err_rstrt", bus.err_rstrt, m_erst);
  endtask

  initial begin
    s1_v = 1'b0; s1_s = 1'b0; s1_l = 1'b0; s1_d = '0;
    e_v = 1'b0; e_s = 1'b0; e_l = 1'b0; e_d = '0;
    m_active = 0; m_idx = 0; m_p = 0; m_ecfg = 1'b0; m_erst = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    check_bit("reset_valid", bus.out_valid, 1'b0);
    check_bus("reset_data", '0);
    rst = 1'b0;

    // 1: cfg_bit=4, no stalls
    for (int b = 0; b < BEATS; b++) begin
      step(1'b1, b == 0, 6'd4, ramp(b));
      if (b == 0) begin
        check_bit("t1_start", bus.out_start, 1'b1);
        check_lane("t1", 1, 28'd16);
        check_lane("t1", 16, 28'd1);
        check_lane("t1", 0, 28'd0);
        check_lane("t1", 17, 28'd17);
        check_lane("t1", 33, 28'd48);
      end
    end
    check_bit("t1_last", bus.out_last, 1'b1);

    // 2: identity frame with cfg_bit wiggling mid-frame, then cfg_bit=5
    for (int b = 0; b < BEATS; b++) begin
      step(1'b1, b == 0, (b == 0) ? 6'd0 : 6'($urandom_range(1, 5)), ramp(b));
      if (b == 2) check_lane("t2_ident", 1, 28'd129);
    end
    for (int b = 0; b < BEATS; b++) begin
      step(1'b1, b == 0, (b == 0) ? 6'd5 : 6'($urandom_range(0, 4)), ramp(b));
      if (b == 0) begin
        check_lane("t2_p5", 1, 28'd32);
        check_lane("t2_p5", 32, 28'd1);
      end
    end

    // 3: three-cycle stall mid-frame
    for (int b = 0; b < 3; b++) step(1'b1, b == 0, 6'd3, ramp(b));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 6'($urandom_range(0, 5)), rnd_bus());
      check_bit("t3_gap", bus.out_valid, 1'b0);
    end
    for (int b = 3; b < BEATS; b++) step(1'b1, 1'b0, 6'd1, ramp(b));
    check_bit("t3_last", bus.out_last, 1'b1);

    // 4: restart at beat 5
    for (int b = 0; b < 5; b++) step(1'b1, b == 0, 6'd2, ramp(b));
    step(1'b1, 1'b1, 6'd1, ramp(0));
    check_bit("t4_rstrt", bus.err_rstrt, 1'b1);
    check_bit("t4_nolast", bus.out_last, 1'b0);
    for (int b = 1; b < BEATS; b++) step(1'b1, 1'b0, 6'd0, ramp(b));
    check_bit("t4_last", bus.out_last, 1'b1);

    // 5: out-of-range partner bit, then stray beat in IDLE
    for (int b = 0; b < BEATS; b++) begin
      step(1'b1, b == 0, 6'd6, ramp(b));
      if (b == 0) begin
        check_bit("t5_errcfg", bus.err_cfg, 1'b1);
        check_lane("t5_ident", 1, 28'd1);
      end
    end
    step(1'b1, 1'b0, 6'd0, ramp(0));
    check_bit("t5_drop", bus.out_valid, 1'b0);

    // 6: reset at beat 4
    for (int b = 0; b < 4; b++) step(1'b1, b == 0, 6'd4, ramp(b));
    rst = 1'b1;
    step(1'b1, 1'b0, 6'd4, ramp(4));
    check_bit("t6_valid", bus.out_valid, 1'b0);
    check_bit("t6_errcfg", bus.err_cfg, 1'b0);
    rst = 1'b0;
    for (int b = 5; b < BEATS; b++) begin
      step(1'b1, 1'b0, 6'd4, ramp(b));
      check_bit("t6_nostart", bus.out_valid, 1'b0);
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
           6'($urandom_range(0, 7)), rnd_bus());
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
